// File: rtl/led_pkg.sv
// Constants shared by the LED request sequencer and the LED on-timer.
package led_pkg;
  localparam int LED_COUNT     = 18;
  localparam int LED_IDX_W     = 5;
  localparam int CLK_PERIOD_NS = 50;

  typedef enum logic [0:0] {IDLE = 1'b0, GAP = 1'b1} seq_state_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;
endpackage

// File: rtl/led_request_sequencer_if.sv
// Request link between the sequencer (master) and the LED on-timer (slave).
interface led_request_sequencer_if #(
  parameter int N = led_pkg::LED_COUNT
) ();
  logic [led_pkg::LED_IDX_W-1:0] led_index;
  logic                          led_request;
  logic [N-1:0]                  led_state;

  modport master (output led_index, output led_request, input led_state);
  modport slave  (input led_index, input led_request, output led_state);
endinterface

// File: rtl/led_rr_picker.sv
// Round-robin picker: lowest set request bit at or above ptr, wrapping to 0.
module led_rr_picker #(
  parameter int N = 18,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // The upper copy supplies the wrapped-around bits below ptr.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N){1'b1}} << ptr);
    found  = |req;
    idx    = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) idx = W'(i % N);
    end
  end
endmodule

// File: rtl/led_request_sequencer.sv
// Collects event rises into a pending mask and issues them round-robin as
// single-cycle LED requests, dropping those whose LED is already lit.
//
// state   | meaning
// ST_IDLE | arbitrate pending bits; issue or drop one per cycle
// ST_GAP  | forced idle after an issue; pending keeps accumulating
module led_request_sequencer #(
  parameter int LED_COUNT      = led_pkg::LED_COUNT,
  parameter int MIN_GAP_CYCLES = 2,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LED_COUNT-1:0]  event_in,
  led_request_sequencer_if.master led,
  output logic [LED_COUNT-1:0]  pending,
  output logic [DROP_CNT_W-1:0] drop_count
);
  import led_pkg::*;

  localparam int GAP_W = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;

  logic [0:0]           state;
  logic [LED_COUNT-1:0] event_prev;
  logic [LED_COUNT-1:0] rise;
  logic [LED_COUNT-1:0] clr;
  logic [LED_IDX_W-1:0] rr_ptr;
  logic [LED_IDX_W-1:0] next_ptr;
  logic [LED_IDX_W-1:0] pick_idx;
  logic                 pick_found;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 take;
  logic                 issue;
  logic                 drop;

  led_rr_picker #(.N(LED_COUNT), .W(LED_IDX_W)) u_picker (
    .req   (pending),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    rise     = event_in & ~event_prev;
    take     = (state == ST_IDLE) && pick_found;
    clr      = take ? ({{(LED_COUNT-1){1'b0}}, 1'b1} << pick_idx) : '0;
    drop     = take && led.led_state[pick_idx];
    issue    = take && !led.led_state[pick_idx];
    next_ptr = (pick_idx == LED_IDX_W'(LED_COUNT-1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      event_prev      <= '0;
      pending         <= '0;
      rr_ptr          <= '0;
      gap_cnt         <= '0;
      drop_count      <= '0;
      led.led_request <= 1'b0;
      led.led_index   <= '0;
    end else begin
      event_prev      <= event_in;
      // A rise on a bit being cleared this cycle is kept.
      pending         <= (pending & ~clr) | rise;
      led.led_request <= issue;
      if (take) rr_ptr <= next_ptr;
      if (issue) led.led_index <= pick_idx;
      if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
      case (state)
        ST_IDLE: begin
          if (issue && (MIN_GAP_CYCLES > 0)) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_W'(MIN_GAP_CYCLES - 1);
          end
        end
        default: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_request_sequencer.sv
// Randomised and directed bench for led_request_sequencer against a queue/array reference model.
module tb_led_request_sequencer;
  import led_pkg::*;

  localparam int N   = LED_COUNT;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] event_in = '0;
  logic [N-1:0] led_state_drv = '0;
  logic [N-1:0] pending, pending_sat;
  logic [15:0]  drop_count;
  logic [1:0]   drop_sat;

  led_request_sequencer_if #(.N(N)) bus ();
  led_request_sequencer_if #(.N(N)) bus_sat ();
  assign bus.led_state     = led_state_drv;
  assign bus_sat.led_state = led_state_drv;

  led_request_sequencer #(.LED_COUNT(N), .MIN_GAP_CYCLES(GAP), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .led(bus),
    .pending(pending), .drop_count(drop_count)
  );

  // Narrow drop counter instance so saturation is reachable in a few events.
  led_request_sequencer #(.LED_COUNT(N), .MIN_GAP_CYCLES(GAP), .DROP_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .led(bus_sat),
    .pending(pending_sat), .drop_count(drop_sat)
  );

  always #(CLK_PERIOD_NS/2) clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pending set, pointer, drop tally, earliest cycle for next issue.
  logic [N-1:0] m_pend, m_prev;
  int m_rr, m_drops, m_ready, cyc, exp_idx;
  logic exp_req;

  function automatic logic [N-1:0] bit_of(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    m_pend = '0; m_prev = '0; m_rr = 0; m_drops = 0; m_ready = 0; cyc = 0;
    exp_req = 1'b0; exp_idx = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; event_in = '0; led_state_drv = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic step(input logic [N-1:0] ev, input logic [N-1:0] st);
    event_in = ev;
    led_state_drv = st;
    exp_req = 1'b0;
    if (cyc >= m_ready) begin
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_rr + j) % N;
        if (m_pend[k]) begin
          m_pend[k] = 1'b0;
          m_rr = (k + 1) % N;
          if (st[k]) m_drops++;
          else begin
            exp_req = 1'b1; exp_idx = k; m_ready = cyc + GAP + 1;
          end
          break;
        end
      end
    end
    for (int k = 0; k < N; k++) if (ev[k] && !m_prev[k]) m_pend[k] = 1'b1;
    m_prev = ev;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++; if (bus.led_request !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", bus.led_request); end
    tests++; if (bus.led_index !== 5'd0) begin fails++; $display("FAIL reset_idx got %0d exp 0", bus.led_index); end
    tests++; if (pending !== '0) begin fails++; $display("FAIL reset_pending got %h exp 0", pending); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
  endtask

  task automatic test_single();
    step(bit_of(3), '0);
    tests++; if (pending !== bit_of(3) || bus.led_request !== 1'b0) begin
      fails++; $display("FAIL single_sample got pend=%h req=%b exp pend=%h req=0", pending, bus.led_request, bit_of(3));
    end
    step(bit_of(3) | bit_of(9), '0);
    tests++; if (bus.led_request !== 1'b1 || bus.led_index !== 5'd3) begin
      fails++; $display("FAIL single_issue got req=%b idx=%0d exp req=1 idx=3", bus.led_request, bus.led_index);
    end
    for (int i = 0; i < 4; i++) begin
      step(bit_of(3) | bit_of(9), '0);
      tests++; if (bus.led_request !== (i == 2) || ((i == 2) && bus.led_index !== 5'd9)) begin
        fails++; $display("FAIL single_gap step=%0d got req=%b idx=%0d exp req=%b idx=9", i, bus.led_request, bus.led_index, (i == 2));
      end
    end
  endtask

  task automatic test_same_cycle();
    int got[$];
    int at[$];
    logic [N-1:0] ev;
    apply_reset();
    ev = bit_of(0) | bit_of(5) | bit_of(17);
    for (int i = 0; i < 12; i++) begin
      step(ev, '0);
      if (bus.led_request === 1'b1) begin got.push_back(int'(bus.led_index)); at.push_back(i); end
      tests++; if (bus.led_request !== exp_req || (exp_req && bus.led_index !== 5'(exp_idx)) || pending !== m_pend) begin
        fails++; $display("FAIL same_cycle step=%0d got req=%b idx=%0d pend=%h exp req=%b idx=%0d pend=%h",
                          i, bus.led_request, bus.led_index, pending, exp_req, exp_idx, m_pend);
      end
    end
    tests++; if (got.size() != 3 || got[0] != 0 || got[1] != 5 || got[2] != 17 || at[1] - at[0] != 3 || at[2] - at[1] != 3) begin
      fails++; $display("FAIL same_cycle_order got n=%0d %p at %p exp 0,5,17 spaced 3", got.size(), got, at);
    end
    tests++; if (pending !== '0) begin fails++; $display("FAIL same_cycle_drain got %h exp 0", pending); end
  endtask

  task automatic test_rr_wrap();
    int got[$];
    step('0, '0);
    for (int i = 0; i < 10; i++) begin
      step(bit_of(2) | bit_of(17), '0);
      if (bus.led_request === 1'b1) got.push_back(int'(bus.led_index));
    end
    tests++; if (got.size() != 2 || got[0] != 2 || got[1] != 17) begin
      fails++; $display("FAIL rr_wrap got n=%0d %p exp 2,17", got.size(), got);
    end
  endtask

  task automatic test_drop();
    int base;
    base = m_drops;
    for (int i = 0; i < 5; i++) begin
      step(bit_of(7), bit_of(7));
      step('0, bit_of(7));
      tests++; if (bus.led_request !== 1'b0 || pending[7] !== 1'b0 || drop_count !== 16'(base + i + 1)) begin
        fails++; $display("FAIL drop iter=%0d got req=%b pend7=%b cnt=%0d exp req=0 pend7=0 cnt=%0d",
                          i, bus.led_request, pending[7], drop_count, base + i + 1);
      end
    end
    tests++; if (drop_sat !== 2'd3) begin fails++; $display("FAIL drop_saturate got %0d exp 3", drop_sat); end
  endtask

  task automatic test_held_level();
    int n_req;
    n_req = 0;
    for (int i = 0; i < 100; i++) begin
      step(bit_of(4), '0);
      if (bus.led_request === 1'b1) begin
        n_req++;
        tests++; if (bus.led_index !== 5'd4) begin fails++; $display("FAIL held_idx got %0d exp 4", bus.led_index); end
      end
    end
    tests++; if (n_req != 1) begin fails++; $display("FAIL held_count got %0d exp 1", n_req); end
    apply_reset();
    step(bit_of(1) | bit_of(4), '0);
    step('0, '0);
    step('0, '0);
    step('0, '0);
    step(bit_of(4), '0);
    tests++; if (bus.led_request !== 1'b1 || bus.led_index !== 5'd4 || pending[4] !== 1'b1) begin
      fails++; $display("FAIL set_wins got req=%b idx=%0d pend4=%b exp req=1 idx=4 pend4=1", bus.led_request, bus.led_index, pending[4]);
    end
    for (int i = 0; i < 3; i++) begin
      step(bit_of(4), '0);
      tests++; if (bus.led_request !== (i == 2) || ((i == 2) && bus.led_index !== 5'd4)) begin
        fails++; $display("FAIL set_wins_reissue step=%0d got req=%b idx=%0d exp req=%b idx=4", i, bus.led_request, bus.led_index, (i == 2));
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [N-1:0] ev;
    apply_reset();
    ev = bit_of(1) | bit_of(2) | bit_of(3) | bit_of(4);
    step(ev, '0);
    step(ev, '0);
    tests++; if (bus.led_request !== 1'b1 || pending !== (bit_of(2) | bit_of(3) | bit_of(4))) begin
      fails++; $display("FAIL mid_gap_setup got req=%b pend=%h exp req=1 pend=%h", bus.led_request, pending, bit_of(2) | bit_of(3) | bit_of(4));
    end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.led_request !== 1'b0 || pending !== '0) begin
      fails++; $display("FAIL mid_gap_reset got req=%b pend=%h exp req=0 pend=0", bus.led_request, pending);
    end
    event_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      step('0, '0);
      tests++; if (bus.led_request !== 1'b0) begin fails++; $display("FAIL post_reset_quiet step=%0d got req=%b exp 0", i, bus.led_request); end
    end
    step(bit_of(6), '0);
    step('0, '0);
    tests++; if (bus.led_request !== 1'b1 || bus.led_index !== 5'd6) begin
      fails++; $display("FAIL post_reset_issue got req=%b idx=%0d exp req=1 idx=6", bus.led_request, bus.led_index);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ev, st;
    apply_reset();
    ev = '0;
    for (int i = 0; i < 400; i++) begin
      ev = ev ^ (N'($urandom) & N'($urandom) & N'($urandom));
      st = N'($urandom) & N'($urandom);
      step(ev, st);
      tests++; if (bus.led_request !== exp_req || (exp_req && bus.led_index !== 5'(exp_idx))) begin
        fails++; $display("FAIL random_req step=%0d got req=%b idx=%0d exp req=%b idx=%0d", i, bus.led_request, bus.led_index, exp_req, exp_idx);
      end
      tests++; if (pending !== m_pend || drop_count !== 16'(m_drops) || drop_sat !== 2'((m_drops > 3) ? 3 : m_drops)) begin
        fails++; $display("FAIL random_state step=%0d got pend=%h drop=%0d sat=%0d exp pend=%h drop=%0d",
                          i, pending, drop_count, drop_sat, m_pend, m_drops);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_same_cycle();
    test_rr_wrap();
    test_drop();
    test_held_level();
    test_reset_mid_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
